// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath sizes and ALU operation codes.
package cpu_pkg;

  localparam int WIDTH   = 32;
  localparam int REGBITS = 5;

  typedef enum logic [3:0] {
    ALU_OR  = 4'b0000,
    ALU_AND = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0100,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } aluop_e;

  // A bubble carries a harmless ADD so the ALU never sees an undefined op.
  localparam logic [3:0] BUBBLE_ALUOP = ALU_ADD;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, forwarding sources and EX outputs.
interface id_ex_stage_if #(
  parameter int WIDTH   = cpu_pkg::WIDTH,
  parameter int REGBITS = cpu_pkg::REGBITS
);
  logic               id_valid;
  logic [REGBITS-1:0] id_rs;
  logic [REGBITS-1:0] id_rt;
  logic [REGBITS-1:0] id_rd;
  logic [WIDTH-1:0]   id_rdata_a;
  logic [WIDTH-1:0]   id_rdata_b;
  logic [WIDTH-1:0]   id_imm;
  logic               id_alusrc;
  logic [3:0]         id_aluop;
  logic               id_regwrite;
  logic               id_memread;
  logic               id_memwrite;
  logic               stall;
  logic               flush;
  logic               exmem_regwrite;
  logic [REGBITS-1:0] exmem_rd;
  logic [WIDTH-1:0]   exmem_result;
  logic               memwb_regwrite;
  logic [REGBITS-1:0] memwb_rd;
  logic [WIDTH-1:0]   memwb_result;
  logic               ex_valid;
  logic [WIDTH-1:0]   regA;
  logic [WIDTH-1:0]   regB;
  logic [3:0]         aluoperation;
  logic [WIDTH-1:0]   ex_store_data;
  logic [REGBITS-1:0] ex_rd;
  logic               ex_regwrite;
  logic               ex_memread;
  logic               ex_memwrite;
  logic               load_use;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rdata_a, id_rdata_b, id_imm,
           id_alusrc, id_aluop, id_regwrite, id_memread, id_memwrite,
           stall, flush, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  ex_valid, regA, regB, aluoperation, ex_store_data, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, load_use
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rdata_a, id_rdata_b, id_imm,
           id_alusrc, id_aluop, id_regwrite, id_memread, id_memwrite,
           stall, flush, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output ex_valid, regA, regB, aluoperation, ex_store_data, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, load_use
  );
endinterface

// File: rtl/fwd_mux.sv
// Two-source priority forwarding mux; EX/MEM beats MEM/WB, r0 never forwards.
module fwd_mux #(
  parameter int WIDTH   = cpu_pkg::WIDTH,
  parameter int REGBITS = cpu_pkg::REGBITS
) (
  input  logic [REGBITS-1:0] src,
  input  logic [WIDTH-1:0]   data,
  input  logic               exmem_regwrite,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               memwb_regwrite,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_result,
  output logic [WIDTH-1:0]   value
);

  // Pick the youngest in-flight producer of src, else the registered data.
  always_comb begin
    value = data;
    if (exmem_regwrite && (exmem_rd == src) && (src != '0)) begin
      value = exmem_result;
    end else if (memwb_regwrite && (memwb_rd == src) && (src != '0)) begin
      value = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH   = cpu_pkg::WIDTH,
  parameter int REGBITS = cpu_pkg::REGBITS
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic               valid;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] rd;
    logic [WIDTH-1:0]   data_a;
    logic [WIDTH-1:0]   data_b;
    logic [WIDTH-1:0]   imm;
    logic               alusrc;
    logic [3:0]         aluop;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
  } ex_reg_t;

  ex_reg_t          ex_q;
  ex_reg_t          ex_nxt;
  ex_reg_t          bubble;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic             load_use;

  fwd_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_a (
    .src(ex_q.rs), .data(ex_q.data_a),
    .exmem_regwrite(bus.exmem_regwrite), .exmem_rd(bus.exmem_rd),
    .exmem_result(bus.exmem_result),
    .memwb_regwrite(bus.memwb_regwrite), .memwb_rd(bus.memwb_rd),
    .memwb_result(bus.memwb_result),
    .value(fwd_a)
  );

  fwd_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_b (
    .src(ex_q.rt), .data(ex_q.data_b),
    .exmem_regwrite(bus.exmem_regwrite), .exmem_rd(bus.exmem_rd),
    .exmem_result(bus.exmem_result),
    .memwb_regwrite(bus.memwb_regwrite), .memwb_rd(bus.memwb_rd),
    .memwb_result(bus.memwb_result),
    .value(fwd_b)
  );

  // Bubble / reset image: everything zero except a benign ADD.
  always_comb begin
    bubble       = '0;
    bubble.aluop = BUBBLE_ALUOP;
  end

  // A load in EX cannot forward yet; rt only matters when it is actually read.
  always_comb begin
    load_use = bus.id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
               ((ex_q.rd == bus.id_rs) ||
                ((ex_q.rd == bus.id_rt) && (!bus.id_alusrc || bus.id_memwrite)));
  end

  // Next contents: flush > stall (refresh forwarded data) > load-use bubble > load.
  always_comb begin
    ex_nxt = ex_q;
    if (bus.flush) begin
      ex_nxt = bubble;
    end else if (bus.stall) begin
      ex_nxt.data_a = fwd_a;
      ex_nxt.data_b = fwd_b;
    end else if (load_use) begin
      ex_nxt = bubble;
    end else begin
      ex_nxt.valid    = bus.id_valid;
      ex_nxt.rs       = bus.id_rs;
      ex_nxt.rt       = bus.id_rt;
      ex_nxt.rd       = bus.id_rd;
      ex_nxt.data_a   = bus.id_rdata_a;
      ex_nxt.data_b   = bus.id_rdata_b;
      ex_nxt.imm      = bus.id_imm;
      ex_nxt.alusrc   = bus.id_alusrc;
      ex_nxt.aluop    = bus.id_aluop;
      ex_nxt.regwrite = bus.id_regwrite;
      ex_nxt.memread  = bus.id_memread;
      ex_nxt.memwrite = bus.id_memwrite;
    end
  end

  // Pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= bubble;
    end else begin
      ex_q <= ex_nxt;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.regA          = fwd_a;
  assign bus.ex_store_data = fwd_b;
  assign bus.regB          = ex_q.alusrc ? ex_q.imm : fwd_b;
  assign bus.aluoperation  = ex_q.aluop;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_regwrite   = ex_q.regwrite;
  assign bus.ex_memread    = ex_q.memread;
  assign bus.ex_memwrite   = ex_q.memwrite;
  assign bus.load_use      = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hazard/stall/flush sequences.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  id_ex_stage_if #(.WIDTH(32), .REGBITS(5)) bus ();

  id_ex_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm;
    logic        alusrc;
    logic [3:0]  op;
    logic        rw, mr, mw;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] e_a, e_b, e_st;
    logic        e_valid;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic alusrc, input logic [3:0] op,
                          input logic rw, input logic mr, input logic mw);
    bus.id_valid    = valid;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.id_rdata_a  = a;
    bus.id_rdata_b  = b;
    bus.id_imm      = imm;
    bus.id_alusrc   = alusrc;
    bus.id_aluop    = op;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_memwrite = mw;
  endtask

  task automatic drive_fwd(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    bus.exmem_regwrite = xw;
    bus.exmem_rd       = xrd;
    bus.exmem_result   = xres;
    bus.memwb_regwrite = ww;
    bus.memwb_rd       = wrd;
    bus.memwb_result   = wres;
  endtask

  task automatic drive_idle();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // valid rs rt rd a b imm alusrc op rw mr mw | xw xrd xres | ww wrd wres | e_a e_b e_st e_valid
    vecs[0] = '{1'b1, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd3, 32'd100, 1'b1, 5'd3, 32'd200, 32'd100, 32'd7, 32'd7, 1'b1};
    vecs[1] = '{1'b1, 5'd6, 5'd2, 5'd10, 32'd1, 32'd3, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd7, 32'd50, 1'b1, 5'd6, 32'd60, 32'd60, 32'd3, 32'd3, 1'b1};
    vecs[2] = '{1'b1, 5'd1, 5'd5, 5'd11, 32'd11, 32'd22, 32'h10, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd5, 32'd99, 1'b0, 5'd0, 32'd0, 32'd11, 32'h10, 32'd99, 1'b1};
    vecs[3] = '{1'b1, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'd0, 32'd0, 32'd0, 1'b1};
    vecs[4] = '{1'b1, 5'd4, 5'd13, 5'd14, 32'd44, 32'd55, 32'd0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0,
                1'b0, 5'd4, 32'd1, 1'b0, 5'd13, 32'd2, 32'd44, 32'd55, 32'd55, 1'b1};
    vecs[5] = '{1'b1, 5'd8, 5'd9, 5'd15, 32'h80, 32'd1, 32'd0, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd9, 32'h900, 1'b1, 5'd9, 32'h901, 32'h80, 32'h900, 32'h900, 1'b1};
    vecs[6] = '{1'b0, 5'd2, 5'd3, 5'd16, 32'd3, 32'd4, 32'd0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd3, 32'd4, 32'd4, 1'b0};
    vecs[7] = '{1'b1, 5'd20, 5'd10, 5'd0, 32'h1000, 32'd5, 32'd8, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1,
                1'b1, 5'd2, 32'd7, 1'b1, 5'd10, 32'h77, 32'h1000, 32'd8, 32'h77, 1'b1};
    vecs[8] = '{1'b1, 5'd1, 5'd0, 5'd12, 32'd2, 32'd0, 32'd4, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd2, 32'd4, 32'd0, 1'b1};

    // Reset held for two cycles with a live instruction on ID
    rst_n = 1'b0;
    drive_idle();
    drive_id(1'b1, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_idle();
    #1;
    chk("rst ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst aluop", 32'(bus.aluoperation), 32'h2);
    chk("rst regwrite", 32'(bus.ex_regwrite), 32'd0);
    chk("rst memread", 32'(bus.ex_memread), 32'd0);
    chk("rst memwrite", 32'(bus.ex_memwrite), 32'd0);
    chk("rst ex_rd", 32'(bus.ex_rd), 32'd0);
    chk("rst regA", bus.regA, 32'd0);
    chk("rst regB", bus.regB, 32'd0);

    // Table-driven forwarding/operand vectors
    for (int i = 0; i < 9; i++) begin
      drive_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].a, vecs[i].b,
               vecs[i].imm, vecs[i].alusrc, vecs[i].op, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      drive_fwd(vecs[i].xw, vecs[i].xrd, vecs[i].xres, vecs[i].ww, vecs[i].wrd, vecs[i].wres);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d regA", i), bus.regA, vecs[i].e_a);
      chk($sformatf("v%0d regB", i), bus.regB, vecs[i].e_b);
      chk($sformatf("v%0d store", i), bus.ex_store_data, vecs[i].e_st);
      chk($sformatf("v%0d ex_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d aluop", i), 32'(bus.aluoperation), 32'(vecs[i].op));
      chk($sformatf("v%0d ex_rd", i), 32'(bus.ex_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d ctrl", i),
          32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}),
          32'({vecs[i].rw, vecs[i].mr, vecs[i].mw}));
    end

    // Load-use: load rd=8 in EX, consumer reads rs=8
    do_reset();
    drive_id(1'b1, 5'd1, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive_id(1'b1, 5'd8, 5'd2, 5'd17, 32'h11, 32'h22, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu asserted", 32'(bus.load_use), 32'd1);
    @(posedge clk);
    #1;
    chk("lu bubble ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu bubble regwrite", 32'(bus.ex_regwrite), 32'd0);
    chk("lu released", 32'(bus.load_use), 32'd0);
    drive_fwd(1'b1, 5'd8, 32'h55, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    chk("lu consumer ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu consumer regA", bus.regA, 32'h55);
    chk("lu consumer regB", bus.regB, 32'h22);
    chk("lu consumer ex_rd", 32'(bus.ex_rd), 32'd17);

    // Load-use on rt depends on whether rt is actually read
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 5'd1, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive_id(1'b1, 5'd3, 5'd8, 5'd18, 32'd0, 32'd0, 32'd4, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu rt imm", 32'(bus.load_use), 32'd0);
    drive_id(1'b1, 5'd3, 5'd8, 5'd18, 32'd0, 32'd0, 32'd4, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);
    #1;
    chk("lu rt store", 32'(bus.load_use), 32'd1);
    drive_id(1'b1, 5'd3, 5'd8, 5'd18, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu rt reg", 32'(bus.load_use), 32'd1);
    drive_id(1'b0, 5'd8, 5'd8, 5'd18, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu id invalid", 32'(bus.load_use), 32'd0);
    drive_id(1'b1, 5'd0, 5'd0, 5'd18, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu no match", 32'(bus.load_use), 32'd0);
    // Stall overrides the load-use bubble but does not mask load_use
    drive_id(1'b1, 5'd8, 5'd0, 5'd18, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    bus.stall = 1'b1;
    #1;
    chk("lu under stall", 32'(bus.load_use), 32'd1);
    @(posedge clk);
    #1;
    chk("lu stall holds load", 32'(bus.ex_memread), 32'd1);
    chk("lu stall holds rd", 32'(bus.ex_rd), 32'd8);
    bus.stall = 1'b0;

    // Stall: a MEM/WB result retiring mid-stall must stick
    do_reset();
    drive_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h10, 32'h20, 32'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("st loaded regA", bus.regA, 32'h10);
    bus.stall = 1'b1;
    drive_id(1'b1, 5'd9, 5'd9, 5'd9, 32'h99, 32'h99, 32'd0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAB);
    @(posedge clk);
    #1;
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("st mid regA", bus.regA, 32'hAB);
    repeat (2) @(posedge clk);
    #1;
    bus.stall = 1'b0;
    #1;
    chk("st after regA", bus.regA, 32'hAB);
    chk("st after regB", bus.regB, 32'h20);
    chk("st after aluop", 32'(bus.aluoperation), 32'h4);
    chk("st after ex_rd", 32'(bus.ex_rd), 32'd7);
    chk("st after ex_valid", 32'(bus.ex_valid), 32'd1);

    // Reset while stalled discards the held instruction
    bus.stall = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.stall = 1'b0;
    chk("rst stall ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst stall regwrite", 32'(bus.ex_regwrite), 32'd0);

    // Flush together with stall: flush wins
    drive_id(1'b1, 5'd2, 5'd3, 5'd4, 32'd1, 32'd2, 32'd0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("fl pre ex_valid", 32'(bus.ex_valid), 32'd1);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    chk("fl ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("fl regwrite", 32'(bus.ex_regwrite), 32'd0);
    chk("fl aluop", 32'(bus.aluoperation), 32'h2);
    chk("fl ex_rd", 32'(bus.ex_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection. It sits directly upstream of the ALU and drives the ALU's `regA`, `regB` and `aluoperation` inputs. It takes decoded fields and register-file read data from ID, and resolves RAW hazards against the EX/MEM and MEM/WB results. It holds on a downstream stall, inserts bubbles on flush and on load-use hazards, and reports those hazards back to the fetch/decode stages.

## Interface
- `WIDTH`, 32, datapath width
- `REGBITS`, 5, register index width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  REGBITS  source and destination indices
- `id_rdata_a`, `id_rdata_b`  in  WIDTH  register-file read data for rs and rt
- `id_imm`  in  WIDTH  sign-extended immediate
- `id_alusrc`  in  1  ALU B operand is the immediate
- `id_aluop`  in  4  ALU operation code: 0000 OR, 0001 AND, 0010 ADD, 0100 XOR, 0110 SUB, 0111 SLT
- `id_regwrite`, `id_memread`, `id_memwrite`  in  1  control bits
- `stall`  in  1  downstream hold
- `flush`  in  1  squash the ID instruction (branch taken)
- `exmem_regwrite`  in  1, `exmem_rd`  in  REGBITS, `exmem_result`  in  WIDTH  EX/MEM forwarding source
- `memwb_regwrite`  in  1, `memwb_rd`  in  REGBITS, `memwb_result`  in  WIDTH  MEM/WB forwarding source
- `ex_valid`  out  1  EX holds a real instruction
- `regA`, `regB`  out  WIDTH  ALU operands
- `aluoperation`  out  4  ALU operation code
- `ex_store_data`  out  WIDTH  forwarded rt value for stores
- `ex_rd`  out  REGBITS  destination index
- `ex_regwrite`, `ex_memread`, `ex_memwrite`  out  1  control bits
- `load_use`  out  1  the ID instruction must be held one cycle

## Operation
- Registered fields: valid, rs, rt, rd, data_a, data_b, imm, alusrc, aluop, regwrite, memread, memwrite.
- Forwarding (combinational on the registered rs and rt):
  - `fwd(r, d)` selects `exmem_result` if `exmem_regwrite` and `exmem_rd == r` and `r != 0`.
  - Otherwise it selects `memwb_result` if `memwb_regwrite` and `memwb_rd == r` and `r != 0`.
  - Otherwise it selects `d`. EX/MEM always has priority over MEM/WB.
- Output muxing:
  - `regA = fwd(rs, data_a)`.
  - `ex_store_data = fwd(rt, data_b)`.
  - `regB = alusrc ? imm : ex_store_data`.
- `load_use` (combinational) is asserted when all of the following hold:
  - `id_valid`, `ex_valid` and `ex_memread` are 1;
  - `ex_rd != 0`;
  - `ex_rd == id_rs`, or `ex_rd == id_rt` and (`!id_alusrc` or `id_memwrite`).
- Per-cycle update, highest priority first:
  1. `!rst_n`: all registers are cleared and aluop is set to 0010.
  2. `flush`: load a bubble.
  3. `stall`: hold every field, but refresh `data_a <= fwd(rs, data_a)` and `data_b <= fwd(rt, data_b)`. This keeps forwarded values that retire during the stall.
  4. `load_use`: load a bubble.
  5. Otherwise: load all fields from ID; `valid <= id_valid`.
- Bubble: `valid`, `regwrite`, `memread` and `memwrite` are 0; indices, data and imm are 0; aluop is 0010.
- `flush` together with `stall`: flush wins.
- `load_use` is not masked by `stall`. Upstream holds ID whenever `stall | load_use`.

## Timing
- Reset values: `ex_valid` 0, `ex_rd` 0, all control outputs 0, `aluoperation` 0010. `regA`, `regB` and `ex_store_data` are 0 when no forwarding source matches.
- Latency: one cycle from ID inputs to registered fields. Forwarding muxes add no cycles, so ALU operands are valid in the same cycle as the registered fields.
- `load_use` is valid in the same cycle as the ID inputs. It deasserts after the bubble enters EX, because the load then moves to EX/MEM and is forwarded.
- Reset mid-stall discards the held instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU opcode constants (`ALU_OR` 0000, `ALU_AND` 0001, `ALU_ADD` 0010, `ALU_XOR` 0100, `ALU_SUB` 0110, `ALU_SLT` 0111);
  - `WIDTH` and `REGBITS` defaults;
  - the bubble aluop (`ALU_ADD`).
- One sub-module: `fwd_mux`, the two-source priority forwarding mux. It is instantiated twice, for rs and rt.

## Test plan
- Reset with `rst_n`=0 for 2 cycles, then release → `ex_valid`=0, `aluoperation`=0010, all control outputs 0.
- ID presents rs=3, data 5; rt=4, data 7; aluop 0110; `exmem_rd`=3 with `exmem_result`=100; `memwb_rd`=3 with `memwb_result`=200; both regwrite bits set → next cycle `regA`=100, `regB`=7.
- Forward targeting r0: `exmem_rd`=0 with regwrite set, registered rs=0 with data 0 → `regA`=0.
- Load-use: EX holds a load with rd=8; ID has rs=8 → `load_use`=1 and the next cycle has `ex_valid`=0. The following cycle, with `exmem_result`=0x55, gives `regA`=0x55.
- Stall for 3 cycles while `memwb_rd`=rs with result 0xAB pulses for 1 cycle → `regA` still 0xAB after the stall releases, and the instruction is unchanged.
- `flush` and `stall` both 1 → next cycle `ex_valid`=0 and `ex_regwrite`=0.
